// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter sequencing controller.
package counter_seq_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/counter_shadow.sv
// Shadow model of the sequenced counter: tracks the expected value,
// counts wraps of the expected value and flags any count mismatch.
module counter_shadow
  import counter_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_zero,
  input  logic             i_step,
  input  logic             i_check,
  input  logic             i_wraps_clr,
  input  logic [CNT_W-1:0] i_count,
  output logic [3:0]       o_wraps,
  output logic             o_err
);

  logic [CNT_W-1:0] r_expected;
  logic [3:0]       r_wraps;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_expected <= '0;
      r_wraps    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (i_load) begin
        r_expected <= i_count;
      end else if (i_zero) begin
        r_expected <= '0;
      end else if (i_step) begin
        r_expected <= r_expected + CNT_W'(1);
      end

      // A wrap is counted on the enabled cycle that moves all-ones back to zero.
      if (i_wraps_clr) begin
        r_wraps <= '0;
      end else if (i_step && (r_expected == '1) && (r_wraps != 4'hF)) begin
        r_wraps <= r_wraps + 4'd1;
      end

      if (i_check && (i_count != r_expected)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_wraps = r_wraps;
  assign o_err   = r_err;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run-length sequencer for an external counter: optional clear, N enabled
// cycles honouring hold, a final compare cycle and a one-cycle done pulse.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_clear,
  input  logic             hold,
  output logic             cnt_reset,
  output logic             cnt_enable,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [3:0]       wraps,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_remaining;
  logic             w_accept;
  logic             w_step;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_step   = reset && (r_state == ST_RUN) && !hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_remaining <= cmd_len;
      end else if (w_step) begin
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_clear)            w_next = ST_CLEAR;
          else if (cmd_len != '0)   w_next = ST_RUN;
          else                      w_next = ST_DONE;
        end
      end
      ST_CLEAR: w_next = (r_remaining == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (!hold && (r_remaining <= LEN_W'(1))) w_next = ST_CHECK;
      end
      ST_CHECK: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so an aborted run never shows busy or done.
  always_comb begin
    cmd_ready  = reset && (r_state == ST_IDLE);
    busy       = reset && (r_state != ST_IDLE);
    done       = reset && (r_state == ST_DONE);
    cnt_reset  = !reset || (r_state == ST_CLEAR);
    cnt_enable = w_step;
  end

  counter_shadow #(
    .CNT_W(CNT_W)
  ) u_shadow (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept && !cmd_clear && (cmd_len != '0)),
    .i_zero     (reset && (r_state == ST_CLEAR)),
    .i_step     (w_step),
    .i_check    (reset && ((r_state == ST_RUN) || (r_state == ST_CHECK))),
    .i_wraps_clr(w_accept),
    .i_count    (count),
    .o_wraps    (wraps),
    .o_err      (err)
  );

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 4: width of the counter being sequenced.
REQ-002 Parameter LEN_W, default 8: width of the run-length command field.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-low (0 = reset, sampled on clk).
REQ-005 Port cmd_valid, input, 1: run command offered.
REQ-006 Port cmd_ready, output, 1: controller accepts a command this cycle.
REQ-007 Port cmd_len, input, LEN_W: number of enabled count cycles requested.
REQ-008 Port cmd_clear, input, 1: clear the counter before running.
REQ-009 Port hold, input, 1: pause request; suppresses enable while high.
REQ-010 Port cnt_reset, output, 1: active-high synchronous reset driven to the counter.
REQ-011 Port cnt_enable, output, 1: enable driven to the counter.
REQ-012 Port count, input, CNT_W: counter value fed back.
REQ-013 Port busy, output, 1: high in any state other than IDLE.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port wraps, output, 4: saturating count of wraps (all-ones to 0) during the last run.
REQ-016 Port err, output, 1: sticky count-mismatch flag.

Function
REQ-017 States SHALL be IDLE, CLEAR, RUN, CHECK, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE with reset high.
- A command is accepted on cmd_valid && cmd_ready.
REQ-019 On accept, the command SHALL be routed as follows:
- cmd_len latched into remaining.
- wraps cleared.
- cmd_clear=1 -> CLEAR.
- cmd_clear=0 and cmd_len!=0 -> RUN, with expected loaded from count.
- cmd_clear=0 and cmd_len=0 -> DONE.
REQ-020 CLEAR SHALL last exactly one cycle with cnt_reset=1 and expected set to 0, then go to DONE if remaining=0, else RUN.
REQ-021 In RUN, cnt_enable SHALL equal !hold, combinationally.
- Each enabled cycle: remaining decrements and expected increments modulo 2^CNT_W.
- Each enabled cycle with expected all-ones: wraps increments, saturating at 15.
REQ-022 RUN SHALL go to CHECK on the enabled cycle where remaining=1.
- hold=1 on that cycle keeps the FSM in RUN.
REQ-023 In RUN and CHECK, count != expected SHALL set err; err clears only on reset.
REQ-024 CHECK SHALL last one cycle (compare only, cnt_enable=0), then go to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, then go to IDLE.
- Run latency, no hold, cmd_clear=1: 1 + 1 + N + 1 + 1 cycles from accept to done.
REQ-026 cnt_enable SHALL be 0 outside RUN; cnt_reset SHALL be 0 outside CLEAR and reset.
REQ-027 cmd_valid outside IDLE SHALL be ignored; commands are not queued.
REQ-028 hold in IDLE, CLEAR, CHECK or DONE SHALL have no effect.

Reset
REQ-029 While reset=0, the block SHALL:
- drive cnt_reset=1, cnt_enable=0, cmd_ready=0;
- set state to IDLE;
- clear remaining, expected, wraps, err, done and busy.
REQ-030 Reset asserted mid-run SHALL abort the run at the next edge with no done pulse.

Structure
REQ-031 Package counter_seq_pkg SHALL hold the state enum and the CNT_W/LEN_W defaults.
REQ-032 The expected-value/wrap/err tracking SHALL be one sub-module, counter_shadow; the FSM stays in the top.

Verification
REQ-033 cmd_len=5, cmd_clear=1, hold=0 -> cnt_reset for 1 cycle, cnt_enable for 5 cycles, count ends at 5, done 9 cycles after accept, err=0, wraps=0.
REQ-034 count preset to 14, cmd_len=20, cmd_clear=0 -> final count 2, wraps=2, err=0.
REQ-035 cmd_len=4 with hold=1 on enabled cycles 2 and 3 -> exactly 4 cnt_enable cycles, done delayed by 2 cycles.
REQ-036 Counter model forced to skip one increment mid-run -> err=1 and stays 1 through the next run until reset.
REQ-037 reset=0 during RUN of cmd_len=10 -> next cycle IDLE, cnt_reset=1, no done pulse.
REQ-038 cmd_len=0, cmd_clear=0 -> done one cycle after accept, no cnt_enable; cmd_valid held during busy -> only one accept.
